// File: rtl/enc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// enc_pkg - widths, LFSR taps and key bundle shared with the encrypter
// Rev 1.0
// ------------------------------------------------------------------
package enc_pkg;
  localparam int RAND9_W = 9;
  localparam int RAND6_W = 6;
  localparam int SEL_W   = 2;
  localparam int DATA_W  = 60;
  localparam int ENC_W   = 76;
  localparam int SEED_W  = RAND9_W + RAND6_W;
  localparam int CNT_W   = 16;

  // Fibonacci taps: x^9+x^5+1 and x^6+x^5+1
  localparam int TAP9_A = 8;
  localparam int TAP9_B = 4;
  localparam int TAP6_A = 5;
  localparam int TAP6_B = 4;

  typedef struct packed {
    logic [RAND9_W-1:0] rand9;
    logic [RAND6_W-1:0] rand6;
    logic [SEL_W-1:0]   func_sel;
  } enc_key_t;
endpackage
`default_nettype wire

// File: rtl/enc_rand_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------
// enc_rand_gen_if - control, seed and key-bundle handshake signals
// Rev 1.0
// ------------------------------------------------------------------
interface enc_rand_gen_if;
  import enc_pkg::*;

  logic               en;
  logic               seed_load;
  logic [SEED_W-1:0]  seed_data;
  logic               key_ready;
  logic               key_valid;
  logic [RAND9_W-1:0] rand9;
  logic [RAND6_W-1:0] rand6;
  logic [SEL_W-1:0]   func_sel;
  logic               seq_wrap;
  logic [CNT_W-1:0]   key_count;

  modport master (
    input  en, seed_load, seed_data, key_ready,
    output key_valid, rand9, rand6, func_sel, seq_wrap, key_count
  );

  modport slave (
    output en, seed_load, seed_data, key_ready,
    input  key_valid, rand9, rand6, func_sel, seq_wrap, key_count
  );
endinterface
`default_nettype wire

// File: rtl/enc_lfsr.sv
`default_nettype none
// ------------------------------------------------------------------
// enc_lfsr - seedable Fibonacci LFSR with load/step/hold and zero-seed guard
// Rev 1.0
// ------------------------------------------------------------------
module enc_lfsr #(
  parameter int               WIDTH = 9,
  parameter int               TAP_A = 8,
  parameter int               TAP_B = 4,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  wire logic             Clk,
  input  wire logic             Rst,
  input  wire logic             i_load,
  input  wire logic             i_step,
  input  wire logic [WIDTH-1:0] i_seed,
  output logic      [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_next;

  // All-zero is the lock-up state, so it falls back to the build-time seed
  always_comb begin
    w_seed = (i_seed == '0) ? SEED : i_seed;
    w_next = {r_q[WIDTH-2:0], r_q[TAP_A] ^ r_q[TAP_B]};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= w_seed;
    end else if (i_step) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/enc_rand_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// enc_rand_gen - LFSR key-material source with valid/ready handshake.
// ENC_RAND_STATS_EN builds key_count and seq_wrap; otherwise both tie to 0.
// Rev 1.0
// ------------------------------------------------------------------
module enc_rand_gen
  import enc_pkg::*;
#(
  parameter logic [RAND9_W-1:0] SEED9 = 9'h1A5,
  parameter logic [RAND6_W-1:0] SEED6 = 6'h2B
) (
  input wire logic       Clk,
  input wire logic       Rst,
  enc_rand_gen_if.master bus
);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WARM = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_valid;
  logic               w_xfer;
  logic               w_step;
  logic [RAND9_W-1:0] w_q9;
  logic [RAND6_W-1:0] w_q6;
  enc_key_t           w_key;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A falling en only takes effect on a transfer so a presented bundle is never dropped
  always_comb begin
    w_state_nxt = r_state;
    if (bus.seed_load) begin
      w_state_nxt = c_WARM;
    end else begin
      case (r_state)
        c_IDLE:  if (bus.en) w_state_nxt = c_WARM;
        c_WARM:  w_state_nxt = c_RUN;
        c_RUN:   if (w_xfer && !bus.en) w_state_nxt = c_IDLE;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_valid = (r_state == c_RUN);
    w_xfer  = w_valid && bus.key_ready;
    w_step  = w_xfer && !bus.seed_load;
  end

  enc_lfsr #(.WIDTH(RAND9_W), .TAP_A(TAP9_A), .TAP_B(TAP9_B), .SEED(SEED9)) u_lfsr9 (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_load (bus.seed_load),
    .i_step (w_step),
    .i_seed (bus.seed_data[SEED_W-1:RAND6_W]),
    .o_q    (w_q9)
  );

  enc_lfsr #(.WIDTH(RAND6_W), .TAP_A(TAP6_A), .TAP_B(TAP6_B), .SEED(SEED6)) u_lfsr6 (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_load (bus.seed_load),
    .i_step (w_step),
    .i_seed (bus.seed_data[RAND6_W-1:0]),
    .o_q    (w_q6)
  );

  always_comb begin
    w_key.rand9    = w_q9;
    w_key.rand6    = w_q6;
    w_key.func_sel = w_q9[SEL_W-1:0] ^ w_q6[SEL_W-1:0];
  end

  assign bus.key_valid = w_valid;
  assign bus.rand9     = w_key.rand9;
  assign bus.rand6     = w_key.rand6;
  assign bus.func_sel  = w_key.func_sel;

`ifdef ENC_RAND_STATS_EN
  logic [RAND9_W-1:0] r_ref9;
  logic [RAND9_W-1:0] w_seed9;
  logic [RAND9_W-1:0] w_next9;
  logic               r_seq_wrap;
  logic [CNT_W-1:0]   r_key_count;

  // Reference follows the seed actually loaded, including the zero-seed fallback
  always_comb begin
    w_seed9 = (bus.seed_data[SEED_W-1:RAND6_W] == '0) ? SEED9 : bus.seed_data[SEED_W-1:RAND6_W];
    w_next9 = {w_q9[RAND9_W-2:0], w_q9[TAP9_A] ^ w_q9[TAP9_B]};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ref9      <= SEED9;
      r_seq_wrap  <= 1'b0;
      r_key_count <= '0;
    end else begin
      if (w_xfer) begin
        r_key_count <= r_key_count + CNT_W'(1);
      end
      r_seq_wrap <= w_step && (w_next9 == r_ref9);
      if (bus.seed_load) begin
        r_ref9 <= w_seed9;
      end
    end
  end

  assign bus.seq_wrap  = r_seq_wrap;
  assign bus.key_count = r_key_count;
`else
  assign bus.seq_wrap  = 1'b0;
  assign bus.key_count = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_enc_rand_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_enc_rand_gen - directed and randomized checks against a behavioural model
// Rev 1.0
// ------------------------------------------------------------------
module tb_enc_rand_gen;
  import enc_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  enc_rand_gen_if bus();

  enc_rand_gen #(.SEED9(9'h1A5), .SEED6(6'h2B)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: plain integers, valid/warm-up flags, last-loaded seed
  int m_r9, m_r6, m_ref9, m_cnt;
  bit m_valid, m_warm, m_wrap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lfsr_next(input int q, input int w, input int ta, input int tb);
    int fb;
    fb = ((q >> ta) ^ (q >> tb)) & 1;
    return ((q << 1) | fb) & ((1 << w) - 1);
  endfunction

  task automatic model_edge();
    bit xfer;
    int s9, s6;
    if (Rst) begin
      m_r9 = 'h1A5; m_r6 = 'h2B; m_ref9 = 'h1A5; m_cnt = 0;
      m_valid = 0; m_warm = 0; m_wrap = 0;
    end else begin
      xfer   = m_valid && bus.key_ready;
      m_wrap = 0;
      if (xfer) m_cnt = (m_cnt + 1) % 65536;
      if (bus.seed_load) begin
        s9 = int'(bus.seed_data[14:6]);
        s6 = int'(bus.seed_data[5:0]);
        m_r9 = (s9 == 0) ? 'h1A5 : s9;
        m_r6 = (s6 == 0) ? 'h2B : s6;
        m_ref9 = m_r9; m_valid = 0; m_warm = 1;
      end else begin
        if (xfer) begin
          m_r9 = lfsr_next(m_r9, 9, 8, 4);
          m_r6 = lfsr_next(m_r6, 6, 5, 4);
          m_wrap = (m_r9 == m_ref9);
        end
        if (m_warm) begin
          m_warm = 0; m_valid = 1;
        end else if (m_valid) begin
          if (xfer && !bus.en) m_valid = 0;
        end else if (bus.en) begin
          m_warm = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("key_valid", bus.key_valid, m_valid);
    chk("rand9", bus.rand9, m_r9);
    chk("rand6", bus.rand6, m_r6);
    chk("func_sel", bus.func_sel, (m_r9 ^ m_r6) & 3);
`ifdef ENC_RAND_STATS_EN
    chk("seq_wrap", bus.seq_wrap, m_wrap);
    chk("key_count", bus.key_count, m_cnt);
`else
    chk("seq_wrap_off", bus.seq_wrap, 0);
    chk("key_count_off", bus.key_count, 0);
`endif
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int wraps;
    logic [15:0] cnt0;
    Rst = 1'b1;
    bus.en = 1'b0; bus.seed_load = 1'b0; bus.seed_data = '0; bus.key_ready = 1'b0;
    tick(); tick();
    chk("rst_rand9", bus.rand9, 9'h1A5);
    chk("rst_rand6", bus.rand6, 6'h2B);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_count", bus.key_count, 0);

    // Start-up latency and first two bundles
    Rst = 1'b0; bus.en = 1'b1; bus.key_ready = 1'b1;
    tick();
    chk("warm_valid", bus.key_valid, 0);
    tick();
    chk("first_valid", bus.key_valid, 1);
    chk("first_r9", bus.rand9, 9'h1A5);
    chk("first_r6", bus.rand6, 6'h2B);
    chk("first_sel", bus.func_sel, 2);
    tick();
    chk("second_r9", bus.rand9, 9'h14B);
    chk("second_r6", bus.rand6, 6'h17);

    // Back-pressure holds the bundle
    bus.key_ready = 1'b0;
    cnt0 = bus.key_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_r9", bus.rand9, 9'h14B);
      chk("hold_valid", bus.key_valid, 1);
      chk("hold_count", bus.key_count, cnt0);
    end

    // Zero seed falls back to build-time seeds
    bus.seed_load = 1'b1; bus.seed_data = 15'h0;
    tick();
    chk("zseed_r9", bus.rand9, 9'h1A5);
    chk("zseed_r6", bus.rand6, 6'h2B);
    chk("zseed_valid", bus.key_valid, 0);
    bus.seed_load = 1'b0;
    tick();
    chk("zseed_valid2", bus.key_valid, 1);

    // Seed load coincident with a transfer
    bus.key_ready = 1'b1; bus.seed_load = 1'b1; bus.seed_data = {9'h001, 6'h01};
    cnt0 = bus.key_count;
    tick();
    bus.seed_load = 1'b0;
    tick();
    chk("sl_r9", bus.rand9, 9'h001);
    chk("sl_r6", bus.rand6, 6'h01);
    chk("sl_valid", bus.key_valid, 1);

    // Full 9-bit period from the loaded seed
    wraps = 0;
    for (int i = 0; i < 511; i++) begin
      tick();
      if (bus.seq_wrap) wraps++;
    end
    chk("period_r9", bus.rand9, 9'h001);
`ifdef ENC_RAND_STATS_EN
    chk("wrap_pulses", wraps, 1);
`else
    chk("wrap_pulses_off", wraps, 0);
`endif

    // en drops while stalled: bundle held, then IDLE after acceptance
    bus.key_ready = 1'b0; bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("endrop_hold", bus.key_valid, 1);
    end
    bus.key_ready = 1'b1;
    tick();
    chk("endrop_idle", bus.key_valid, 0);
    tick();
    chk("endrop_idle2", bus.key_valid, 0);

    // Reset mid-stream
    bus.en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    Rst = 1'b1;
    tick();
    chk("midrst_r9", bus.rand9, 9'h1A5);
    chk("midrst_valid", bus.key_valid, 0);
    chk("midrst_count", bus.key_count, 0);
    Rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.en        = ($urandom_range(0, 7) != 0);
      bus.key_ready = $urandom_range(0, 1) == 1;
      bus.seed_load = ($urandom_range(0, 31) == 0);
      bus.seed_data = ($urandom_range(0, 7) == 0) ? 15'h0 : 15'($urandom);
      Rst           = ($urandom_range(0, 199) == 0);
      tick();
    end

`ifdef ENC_RAND_STATS_EN
    // Counter wraps after 65536 transfers
    Rst = 1'b1; bus.seed_load = 1'b0; bus.en = 1'b1; bus.key_ready = 1'b1;
    tick();
    Rst = 1'b0;
    tick(); tick();
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (i == 65534) chk("count_max", bus.key_count, 16'hFFFF);
    end
    chk("count_wrap", bus.key_count, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
